// File: rtl/student_iis_pkg.sv
// ============================================================================
// Module      : student_iis_pkg
// Description : Shared I2S constants, receiver FSM state type and channel enum.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package student_iis_pkg;

    localparam int IIS_MIN_DATA_SIZE = 8;
    localparam int IIS_MAX_DATA_SIZE = 32;
    localparam int IIS_MAX_SLOT_BITS = 64;
    localparam int IIS_CNT_W         = 6;

    typedef logic [1:0] iis_rx_state_e;

    localparam iis_rx_state_e IIS_ST_UNSYNC = 2'd0;
    localparam iis_rx_state_e IIS_ST_SKIP   = 2'd1;
    localparam iis_rx_state_e IIS_ST_SHIFT  = 2'd2;
    localparam iis_rx_state_e IIS_ST_PAD    = 2'd3;

    typedef enum logic {
        IIS_CH_LEFT  = 1'b0,
        IIS_CH_RIGHT = 1'b1
    } iis_channel_e;

endpackage

`default_nettype wire

// File: rtl/student_iis_receiver.sv
// ============================================================================
// Module      : student_iis_receiver
// Description : Standard I2S stereo receiver driven by BCLK/LRCLK edge strobes.
//               Optional frame error counter enabled by STUDENT_IIS_RX_ERRCNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module student_iis_receiver
    import student_iis_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 AC_ADC_SDATA,
    input  logic                 BCLK_Rise,
    input  logic                 LRCLK_Fall,
    input  logic                 LRCLK_Rise,
    output logic [DATA_SIZE-1:0] sample_left_o,
    output logic [DATA_SIZE-1:0] sample_right_o,
    output logic                 valid_strobe_out,
    output logic                 busy_o
`ifdef STUDENT_IIS_RX_ERRCNT_EN
    ,
    output logic [7:0]           frame_err_cnt_o
`endif
);

    if (DATA_SIZE < IIS_MIN_DATA_SIZE || DATA_SIZE > IIS_MAX_DATA_SIZE ||
        SLOT_BITS <= DATA_SIZE || SLOT_BITS > IIS_MAX_SLOT_BITS) begin : g_param_check
        $error("student_iis_receiver: DATA_SIZE/SLOT_BITS out of range");
    end

    localparam logic [IIS_CNT_W-1:0] LAST_BIT = IIS_CNT_W'(DATA_SIZE - 1);

    iis_rx_state_e          state_q,       state_d;
    iis_channel_e           chan_q,        chan_d;
    logic [IIS_CNT_W-1:0]   cnt_q,         cnt_d;
    logic [DATA_SIZE-2:0]   shreg_q,       shreg_d;
    logic [DATA_SIZE-1:0]   left_hold_q,   left_hold_d;
    logic                   left_ok_q,     left_ok_d;
    logic [DATA_SIZE-1:0]   sample_left_q, sample_left_d;
    logic [DATA_SIZE-1:0]   sample_right_q, sample_right_d;
    logic                   valid_q,       valid_d;
    logic                   frame_err;
    logic [DATA_SIZE-1:0]   shift_next;

    assign shift_next = {shreg_q, AC_ADC_SDATA};

    always_comb begin
        state_d        = state_q;
        chan_d         = chan_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        left_hold_d    = left_hold_q;
        left_ok_d      = left_ok_q;
        sample_left_d  = sample_left_q;
        sample_right_d = sample_right_q;
        valid_d        = 1'b0;
        frame_err      = 1'b0;

        if (LRCLK_Fall && LRCLK_Rise) begin
            state_d   = IIS_ST_UNSYNC;
            cnt_d     = '0;
            left_ok_d = 1'b0;
            frame_err = 1'b1;
        end else if (state_q == IIS_ST_UNSYNC) begin
            if (LRCLK_Fall) begin
                state_d = IIS_ST_SKIP;
                chan_d  = IIS_CH_LEFT;
                cnt_d   = '0;
            end
        end else if (LRCLK_Fall || LRCLK_Rise) begin
            // LRCLK edges win over a coincident BCLK_Rise, so it never counts as the skip bit
            state_d = IIS_ST_SKIP;
            chan_d  = LRCLK_Rise ? IIS_CH_RIGHT : IIS_CH_LEFT;
            cnt_d   = '0;
            if (state_q == IIS_ST_SKIP || state_q == IIS_ST_SHIFT) begin
                left_ok_d = 1'b0;
                frame_err = 1'b1;
            end else if (LRCLK_Fall) begin
                left_ok_d = 1'b0;
            end
        end else if (BCLK_Rise) begin
            case (state_q)
                IIS_ST_SKIP: begin
                    state_d = IIS_ST_SHIFT;
                    cnt_d   = '0;
                end
                IIS_ST_SHIFT: begin
                    shreg_d = shift_next[DATA_SIZE-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = IIS_ST_PAD;
                        if (chan_q == IIS_CH_LEFT) begin
                            left_hold_d = shift_next;
                            left_ok_d   = 1'b1;
                        end else begin
                            // a right word only publishes when paired with this frame's left word
                            if (left_ok_q) begin
                                sample_left_d  = left_hold_q;
                                sample_right_d = shift_next;
                                valid_d        = 1'b1;
                            end
                            left_ok_d = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IIS_ST_UNSYNC;
            chan_q         <= IIS_CH_LEFT;
            cnt_q          <= '0;
            shreg_q        <= '0;
            left_hold_q    <= '0;
            left_ok_q      <= 1'b0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            left_hold_q    <= left_hold_d;
            left_ok_q      <= left_ok_d;
            sample_left_q  <= sample_left_d;
            sample_right_q <= sample_right_d;
            valid_q        <= valid_d;
        end
    end

`ifdef STUDENT_IIS_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign frame_err_cnt_o = err_cnt_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err;
`endif

    assign sample_left_o    = sample_left_q;
    assign sample_right_o   = sample_right_q;
    assign valid_strobe_out = valid_q;
    assign busy_o           = (state_q == IIS_ST_SKIP) || (state_q == IIS_ST_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_student_iis_receiver.sv
// ============================================================================
// Module      : tb_student_iis_receiver
// Description : Directed bench for student_iis_receiver, 16-bit and 24-bit
//               instances fed from one shared I2S stream with 32-bit slots.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_student_iis_receiver;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic sdata = 1'b0;
    logic bclk_rise = 1'b0;
    logic lr_fall = 1'b0;
    logic lr_rise = 1'b0;

    logic [15:0] l16, r16;
    logic [23:0] l24, r24;
    logic        v16, v24, busy16, busy24;
`ifdef STUDENT_IIS_RX_ERRCNT_EN
    logic [7:0]  err16, err24;
    logic [7:0]  e0;
`endif

    int checks = 0;
    int errors = 0;
    int p16 = 0;
    int p24 = 0;
    int pb16, pb24;

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (v16 === 1'b1) p16++;
        if (v24 === 1'b1) p24++;
    end

    student_iis_receiver #(.DATA_SIZE(16), .SLOT_BITS(32)) dut16 (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .AC_ADC_SDATA     (sdata),
        .BCLK_Rise        (bclk_rise),
        .LRCLK_Fall       (lr_fall),
        .LRCLK_Rise       (lr_rise),
        .sample_left_o    (l16),
        .sample_right_o   (r16),
        .valid_strobe_out (v16),
        .busy_o           (busy16)
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        ,
        .frame_err_cnt_o  (err16)
`endif
    );

    student_iis_receiver #(.DATA_SIZE(24), .SLOT_BITS(32)) dut24 (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .AC_ADC_SDATA     (sdata),
        .BCLK_Rise        (bclk_rise),
        .LRCLK_Fall       (lr_fall),
        .LRCLK_Rise       (lr_rise),
        .sample_left_o    (l24),
        .sample_right_o   (r24),
        .valid_strobe_out (v24),
        .busy_o           (busy24)
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        ,
        .frame_err_cnt_o  (err24)
`endif
    );

    // One BCLK rise: data valid with the strobe, then an idle cycle.
    task automatic bit_rise(input logic b);
        sdata     = b;
        bclk_rise = 1'b1;
        @(negedge clk_i);
        bclk_rise = 1'b0;
        @(negedge clk_i);
    endtask

    // Word is MSB-aligned in 32 bits; rise 0 is the skip bit, rises 1..32 carry word[31..0].
    task automatic send_slot(input bit right, input logic [31:0] word, input int rises, input bit coincident);
        @(negedge clk_i);
        lr_fall   = !right;
        lr_rise   = right;
        bclk_rise = coincident;
        sdata     = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        lr_fall   = 1'b0;
        lr_rise   = 1'b0;
        bclk_rise = 1'b0;
        for (int i = 0; i < rises; i++) begin
            if (i >= 1 && i <= 32) bit_rise(word[32-i]);
            else                   bit_rise(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw);
        send_slot(1'b0, lw, 32, 1'b0);
        send_slot(1'b1, rw, 32, 1'b0);
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({l16, r16, v16, busy16} !== 34'd0) begin
            errors++;
            $display("FAIL reset_dut16: got l=%h r=%h v=%b busy=%b, want all 0", l16, r16, v16, busy16);
        end
        checks++;
        if ({l24, r24, v24, busy24} !== 50'd0) begin
            errors++;
            $display("FAIL reset_dut24: got l=%h r=%h v=%b busy=%b, want all 0", l24, r24, v24, busy24);
        end
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        checks++;
        if (err16 !== 8'd0) begin
            errors++;
            $display("FAIL reset_errcnt: got %0d, want 0", err16);
        end
`endif
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    // Left 8001 / right 7FFE with cycle-exact pulse placement, then a second frame.
    task automatic test_basic;
        logic [31:0] rw;
        rw = 32'h7FFE_C3A5;
        pb16 = p16;
        pb24 = p24;
        send_slot(1'b0, 32'h8001_5A3C, 32, 1'b0);
        @(negedge clk_i);
        lr_rise = 1'b1;
        @(negedge clk_i);
        lr_rise = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sdata     = (i >= 1) ? rw[32-i] : 1'b0;
            bclk_rise = 1'b1;
            @(negedge clk_i);
            if (i == 5) begin
                checks++;
                if (busy16 !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_shift: got %b, want 1", busy16);
                end
            end
            if (i == 15) begin
                checks++;
                if ({v16, l16} !== 17'd0) begin
                    errors++;
                    $display("FAIL left_held_early: got v=%b l=%h, want v=0 l=0000", v16, l16);
                end
            end
            if (i == 16) begin
                checks++;
                if ({v16, l16, r16} !== {1'b1, 16'h8001, 16'h7FFE}) begin
                    errors++;
                    $display("FAIL pulse16_timing: got v=%b l=%h r=%h, want v=1 l=8001 r=7FFE", v16, l16, r16);
                end
            end
            if (i == 24) begin
                checks++;
                if ({v24, l24, r24} !== {1'b1, 24'h80015A, 24'h7FFEC3}) begin
                    errors++;
                    $display("FAIL pulse24_timing: got v=%b l=%h r=%h, want v=1 l=80015A r=7FFEC3", v24, l24, r24);
                end
            end
            bclk_rise = 1'b0;
            @(negedge clk_i);
            if (i == 16) begin
                checks++;
                if (v16 !== 1'b0) begin
                    errors++;
                    $display("FAIL pulse16_width: got v=%b one cycle later, want 0", v16);
                end
            end
        end
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_pad: got %b, want 0", busy16);
        end
        checks++;
        if (p16 !== pb16 + 1 || p24 !== pb24 + 1) begin
            errors++;
            $display("FAIL basic_pulse_count: got %0d/%0d, want %0d/%0d", p16 - pb16, p24 - pb24, 1, 1);
        end
        pb16 = p16;
        send_frame(32'h1234_5678, 32'hFEDC_BA98);
        checks++;
        if (p16 !== pb16 + 1 || {l16, r16} !== {16'h1234, 16'hFEDC} || {l24, r24} !== {24'h123456, 24'hFEDCBA}) begin
            errors++;
            $display("FAIL basic_frame2: got n=%0d l=%h r=%h l24=%h r24=%h, want n=1 1234 FEDC 123456 FEDCBA",
                     p16 - pb16, l16, r16, l24, r24);
        end
    endtask

    task automatic test_unsync;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        pb16 = p16;
        for (int i = 0; i < 40; i++) begin
            lr_rise = (i % 13 == 4);
            bit_rise(1'($urandom_range(0, 1)));
            lr_rise = 1'b0;
        end
        send_slot(1'b1, 32'hFFFF_FFFF, 32, 1'b0);
        checks++;
        if (p16 !== pb16 || {l16, r16, busy16} !== 33'd0) begin
            errors++;
            $display("FAIL unsync_ignored: got n=%0d l=%h r=%h busy=%b, want n=0 zeros", p16 - pb16, l16, r16, busy16);
        end
        send_frame(32'hA5A5_0F0F, 32'h5A5A_F0F0);
        checks++;
        if (p16 !== pb16 + 1 || {l16, r16} !== {16'hA5A5, 16'h5A5A} || {l24, r24} !== {24'hA5A50F, 24'h5A5AF0}) begin
            errors++;
            $display("FAIL unsync_first_frame: got n=%0d l=%h r=%h l24=%h r24=%h, want n=1 A5A5 5A5A A5A50F 5A5AF0",
                     p16 - pb16, l16, r16, l24, r24);
        end
    endtask

    task automatic test_short_slot;
        pb16 = p16;
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        e0 = err16;
`endif
        send_slot(1'b0, 32'h1111_2222, 11, 1'b0);
        send_slot(1'b1, 32'h3333_4444, 32, 1'b0);
        checks++;
        if (p16 !== pb16 || {l16, r16} !== {16'hA5A5, 16'h5A5A}) begin
            errors++;
            $display("FAIL short_slot_no_pulse: got n=%0d l=%h r=%h, want n=0 A5A5 5A5A", p16 - pb16, l16, r16);
        end
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        checks++;
        if (err16 !== e0 + 8'd1) begin
            errors++;
            $display("FAIL short_slot_errcnt: got %0d, want %0d", err16, e0 + 8'd1);
        end
`endif
        send_frame(32'hCAFE_BABE, 32'hDEAD_BEEF);
        checks++;
        if (p16 !== pb16 + 1 || {l16, r16} !== {16'hCAFE, 16'hDEAD} || {l24, r24} !== {24'hCAFEBA, 24'hDEADBE}) begin
            errors++;
            $display("FAIL short_slot_recover: got n=%0d l=%h r=%h l24=%h r24=%h, want n=1 CAFE DEAD CAFEBA DEADBE",
                     p16 - pb16, l16, r16, l24, r24);
        end
    endtask

    task automatic test_right_only;
        pb16 = p16;
        send_slot(1'b1, 32'h0F0F_0F0F, 32, 1'b0);
        checks++;
        if (p16 !== pb16 || {l16, r16} !== {16'hCAFE, 16'hDEAD}) begin
            errors++;
            $display("FAIL right_only_discard: got n=%0d l=%h r=%h, want n=0 CAFE DEAD", p16 - pb16, l16, r16);
        end
    endtask

    // LRCLK strobes that land on a BCLK_Rise must not consume the skip bit.
    task automatic test_coincident;
        pb16 = p16;
        send_slot(1'b0, 32'h9C3E_6B21, 32, 1'b1);
        send_slot(1'b1, 32'h4D7A_E58F, 32, 1'b1);
        @(negedge clk_i);
        checks++;
        if (p16 !== pb16 + 1 || {l16, r16} !== {16'h9C3E, 16'h4D7A} || {l24, r24} !== {24'h9C3E6B, 24'h4D7AE5}) begin
            errors++;
            $display("FAIL coincident_edge: got n=%0d l=%h r=%h l24=%h r24=%h, want n=1 9C3E 4D7A 9C3E6B 4D7AE5",
                     p16 - pb16, l16, r16, l24, r24);
        end
    endtask

    task automatic test_simultaneous;
        pb16 = p16;
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        e0 = err16;
`endif
        send_slot(1'b0, 32'h1357_9BDF, 32, 1'b0);
        @(negedge clk_i);
        lr_fall = 1'b1;
        lr_rise = 1'b1;
        @(negedge clk_i);
        lr_fall = 1'b0;
        lr_rise = 1'b0;
        send_slot(1'b1, 32'h2468_ACE0, 32, 1'b0);
        checks++;
        if (p16 !== pb16 || busy16 !== 1'b0 || {l16, r16} !== {16'h9C3E, 16'h4D7A}) begin
            errors++;
            $display("FAIL simultaneous_unsync: got n=%0d busy=%b l=%h r=%h, want n=0 busy=0 9C3E 4D7A",
                     p16 - pb16, busy16, l16, r16);
        end
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        checks++;
        if (err16 !== e0 + 8'd1) begin
            errors++;
            $display("FAIL simultaneous_errcnt: got %0d, want %0d", err16, e0 + 8'd1);
        end
`endif
        send_frame(32'h0000_FFFF, 32'hFFFF_0000);
        checks++;
        if (p16 !== pb16 + 1 || {l16, r16} !== {16'h0000, 16'hFFFF}) begin
            errors++;
            $display("FAIL simultaneous_recover: got n=%0d l=%h r=%h, want n=1 0000 FFFF", p16 - pb16, l16, r16);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rw;
        rw = 32'h6789_ABCD;
        send_slot(1'b0, 32'hFEED_F00D, 32, 1'b0);
        @(negedge clk_i);
        lr_rise = 1'b1;
        @(negedge clk_i);
        lr_rise = 1'b0;
        for (int i = 0; i <= 8; i++) bit_rise((i >= 1) ? rw[32-i] : 1'b0);
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy_before: got %b, want 1", busy16);
        end
        pb16 = p16;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({l16, r16, v16, busy16} !== 34'd0 || {l24, r24, v24, busy24} !== 50'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got l=%h r=%h v=%b busy=%b l24=%h r24=%h, want all 0",
                     l16, r16, v16, busy16, l24, r24);
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 9; i < 32; i++) bit_rise(rw[32-i]);
        checks++;
        if (p16 !== pb16 || {l16, r16} !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse: got n=%0d l=%h r=%h, want n=0 zeros", p16 - pb16, l16, r16);
        end
        send_frame(32'h0BAD_C0DE, 32'h7777_1111);
        checks++;
        if (p16 !== pb16 + 1 || {l16, r16} !== {16'h0BAD, 16'h7777} || {l24, r24} !== {24'h0BADC0, 24'h777711}) begin
            errors++;
            $display("FAIL reset_mid_recover: got n=%0d l=%h r=%h l24=%h r24=%h, want n=1 0BAD 7777 0BADC0 777711",
                     p16 - pb16, l16, r16, l24, r24);
        end
    endtask

    task automatic test_random;
        logic [31:0] lw, rw;
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        e0 = err24;
`endif
        for (int f = 0; f < 300; f++) begin
            lw   = 32'($urandom);
            rw   = 32'($urandom);
            pb16 = p16;
            pb24 = p24;
            send_frame(lw, rw);
            checks++;
            if (p16 !== pb16 + 1 || {l16, r16} !== {lw[31:16], rw[31:16]}) begin
                errors++;
                $display("FAIL random16 frame %0d: got n=%0d l=%h r=%h, want n=1 l=%h r=%h",
                         f, p16 - pb16, l16, r16, lw[31:16], rw[31:16]);
            end
            checks++;
            if (p24 !== pb24 + 1 || {l24, r24} !== {lw[31:8], rw[31:8]}) begin
                errors++;
                $display("FAIL random24 frame %0d: got n=%0d l=%h r=%h, want n=1 l=%h r=%h",
                         f, p24 - pb24, l24, r24, lw[31:8], rw[31:8]);
            end
        end
`ifdef STUDENT_IIS_RX_ERRCNT_EN
        checks++;
        if (err24 !== e0) begin
            errors++;
            $display("FAIL random_errcnt: got %0d, want %0d", err24, e0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unsync();
        test_short_slot();
        test_right_only();
        test_coincident();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
